// File: rtl/encode.sv
// rtl/encode.sv - 6502 instruction encoder/emitter: one (opcode, mode, operand) tuple in, machine-code bytes out
package common_types;
  typedef enum logic [5:0] {
    OP_ORA, OP_AND, OP_EOR, OP_ADC, OP_STA, OP_LDA, OP_CMP, OP_SBC,
    OP_ASL, OP_ROL, OP_LSR, OP_ROR, OP_STX, OP_LDX, OP_DEC, OP_INC,
    OP_BIT, OP_JMP, OP_STY, OP_LDY, OP_CPY, OP_CPX,
    OP_BRK, OP_RTI, OP_RTS, OP_PHP, OP_PLP, OP_PHA, OP_PLA, OP_CLC,
    OP_SEC, OP_CLI, OP_SEI, OP_CLV, OP_CLD, OP_SED, OP_TYA, OP_DEY,
    OP_TAY, OP_INY, OP_INX, OP_TXA, OP_TXS, OP_TAX, OP_TSX, OP_DEX,
    OP_NOP, OP_JSR,
    OP_BPL, OP_BMI, OP_BVC, OP_BVS, OP_BCC, OP_BCS, OP_BNE, OP_BEQ
  } opc_t;

  typedef enum logic [3:0] {
    M_IMP, M_ACC, M_IMM, M_ZP, M_ZPX, M_ZPY,
    M_ABS, M_ABSX, M_ABSY, M_IXID, M_IDIX, M_REL
  } addmod_t;
endpackage

module encode
  import common_types::*;
#(
  parameter logic [15:0] START_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  opc_t        in_opcode,
  input  addmod_t     in_mode,
  input  logic [15:0] in_operand,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [15:0] out_addr,
  output logic        instr_done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPB  = 3'd1;
  localparam logic [2:0] S_LOB  = 3'd2;
  localparam logic [2:0] S_HIB  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  opc_q, opc_d;
  logic [15:0] opr_q, opr_d;
  logic [1:0]  len_q, len_d;
  logic        done;

  logic        enc_legal;
  logic [7:0]  enc_byte;
  logic [1:0]  enc_len;
  logic [2:0]  bbb_a;      // mode field for the cc=01 (ALU) group
  logic [2:0]  bbb_b;      // mode field shared by the cc=10 and cc=00 groups
  logic        bbb_a_ok;
  logic        bbb_b_ok;

  // Encode the presented tuple: opcode byte, legality and total byte count
  always_comb begin
    enc_legal = 1'b0;
    enc_byte  = 8'h00;
    bbb_a     = 3'd0;
    bbb_a_ok  = 1'b1;
    bbb_b     = 3'd0;
    bbb_b_ok  = 1'b1;
    case (in_mode)
      M_IXID:  bbb_a = 3'd0;
      M_ZP:    bbb_a = 3'd1;
      M_IMM:   bbb_a = 3'd2;
      M_ABS:   bbb_a = 3'd3;
      M_IDIX:  bbb_a = 3'd4;
      M_ZPX:   bbb_a = 3'd5;
      M_ABSY:  bbb_a = 3'd6;
      M_ABSX:  bbb_a = 3'd7;
      default: bbb_a_ok = 1'b0;
    endcase
    case (in_mode)
      M_IMM:         bbb_b = 3'd0;
      M_ZP:          bbb_b = 3'd1;
      M_ACC:         bbb_b = 3'd2;
      M_ABS:         bbb_b = 3'd3;
      M_ZPX, M_ZPY:  bbb_b = 3'd5;
      M_ABSX, M_ABSY: bbb_b = 3'd7;
      default:       bbb_b_ok = 1'b0;
    endcase

    if (in_opcode <= OP_SBC) begin
      enc_byte  = {in_opcode[2:0], bbb_a, 2'b01};
      enc_legal = bbb_a_ok && !(in_opcode == OP_STA && in_mode == M_IMM);
    end else if (in_opcode <= OP_INC) begin
      enc_byte = {in_opcode[2:0], bbb_b, 2'b10};
      case (in_opcode)
        OP_STX:         enc_legal = in_mode inside {M_ZP, M_ABS, M_ZPY};
        OP_LDX:         enc_legal = in_mode inside {M_IMM, M_ZP, M_ABS, M_ZPY, M_ABSY};
        OP_DEC, OP_INC: enc_legal = in_mode inside {M_ZP, M_ABS, M_ZPX, M_ABSX};
        default:        enc_legal = in_mode inside {M_ACC, M_ZP, M_ABS, M_ZPX, M_ABSX};
      endcase
      enc_legal = enc_legal && bbb_b_ok;
    end else if (in_opcode <= OP_CPX) begin
      case (in_opcode)
        OP_BIT: begin
          enc_byte  = {3'd1, bbb_b, 2'b00};
          enc_legal = in_mode inside {M_ZP, M_ABS};
        end
        OP_JMP: begin
          enc_byte  = {3'd2, bbb_b, 2'b00};
          enc_legal = (in_mode == M_ABS);
        end
        OP_STY: begin
          enc_byte  = {3'd4, bbb_b, 2'b00};
          enc_legal = in_mode inside {M_ZP, M_ABS, M_ZPX};
        end
        OP_LDY: begin
          enc_byte  = {3'd5, bbb_b, 2'b00};
          enc_legal = in_mode inside {M_IMM, M_ZP, M_ABS, M_ZPX, M_ABSX};
        end
        OP_CPY: begin
          enc_byte  = {3'd6, bbb_b, 2'b00};
          enc_legal = in_mode inside {M_IMM, M_ZP, M_ABS};
        end
        default: begin
          enc_byte  = {3'd7, bbb_b, 2'b00};
          enc_legal = in_mode inside {M_IMM, M_ZP, M_ABS};
        end
      endcase
    end else if (in_opcode == OP_JSR) begin
      enc_byte  = 8'h20;
      enc_legal = (in_mode == M_ABS);
    end else if (in_opcode >= OP_BPL) begin
      enc_byte  = {in_opcode[2:0], 5'b10000};
      enc_legal = (in_mode == M_REL);
    end else begin
      enc_legal = (in_mode == M_IMP);
      case (in_opcode)
        OP_BRK: enc_byte = 8'h00;  OP_RTI: enc_byte = 8'h40;
        OP_RTS: enc_byte = 8'h60;  OP_PHP: enc_byte = 8'h08;
        OP_PLP: enc_byte = 8'h28;  OP_PHA: enc_byte = 8'h48;
        OP_PLA: enc_byte = 8'h68;  OP_CLC: enc_byte = 8'h18;
        OP_SEC: enc_byte = 8'h38;  OP_CLI: enc_byte = 8'h58;
        OP_SEI: enc_byte = 8'h78;  OP_CLV: enc_byte = 8'hB8;
        OP_CLD: enc_byte = 8'hD8;  OP_SED: enc_byte = 8'hF8;
        OP_TYA: enc_byte = 8'h98;  OP_DEY: enc_byte = 8'h88;
        OP_TAY: enc_byte = 8'hA8;  OP_INY: enc_byte = 8'hC8;
        OP_INX: enc_byte = 8'hE8;  OP_TXA: enc_byte = 8'h8A;
        OP_TXS: enc_byte = 8'h9A;  OP_TAX: enc_byte = 8'hAA;
        OP_TSX: enc_byte = 8'hBA;  OP_DEX: enc_byte = 8'hCA;
        default: enc_byte = 8'hEA;
      endcase
    end

    case (in_mode)
      M_IMP, M_ACC:          enc_len = 2'd1;
      M_ABS, M_ABSX, M_ABSY: enc_len = 2'd3;
      default:               enc_len = 2'd2;
    endcase
  end

  // Next-state: accept/load in IDLE, step through bytes on each sink handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    opc_d   = opc_q;
    opr_d   = opr_q;
    len_d   = len_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          addr_d = load_addr;
        end else if (in_valid) begin
          if (enc_legal) begin
            state_d = S_OPB;
            opc_d   = enc_byte;
            opr_d   = in_operand;
            len_d   = enc_len;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_OPB: begin
        if (out_ready) begin
          addr_d = addr_q + 16'd1;
          if (len_q == 2'd1) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOB;
          end
        end
      end
      S_LOB: begin
        if (out_ready) begin
          addr_d = addr_q + 16'd1;
          if (len_q == 2'd2) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_HIB;
          end
        end
      end
      S_HIB: begin
        if (out_ready) begin
          addr_d  = addr_q + 16'd1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= START_ADDR;
      opc_q   <= 8'h00;
      opr_q   <= 16'h0000;
      len_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      opc_q   <= opc_d;
      opr_q   <= opr_d;
      len_q   <= len_d;
    end
  end

  // Output byte selection by emit phase
  always_comb begin
    case (state_q)
      S_OPB:   out_data = opc_q;
      S_LOB:   out_data = opr_q[7:0];
      S_HIB:   out_data = opr_q[15:8];
      default: out_data = 8'h00;
    endcase
  end

  assign in_ready   = (state_q == S_IDLE) && !load_en;
  assign out_valid  = (state_q == S_OPB) || (state_q == S_LOB) || (state_q == S_HIB);
  assign out_addr   = addr_q;
  assign instr_done = done;
  assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_encode.sv
// tb/tb_encode.sv - randomized self-checking bench for encode against a 6502 opcode-table model
module tb_encode;
  import common_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  opc_t        in_opcode;
  addmod_t     in_mode;
  logic [15:0] in_operand;
  logic        load_en;
  logic [15:0] load_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_addr;
  logic        instr_done;
  logic        err;

  encode #(.START_ADDR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_mode(in_mode), .in_operand(in_operand),
    .load_en(load_en), .load_addr(load_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .instr_done(instr_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    opc_t        op;
    addmod_t     md;
    logic [7:0]  b;
  } ent_t;

  ent_t        tab[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input opc_t o, input addmod_t m, input logic [7:0] b);
    ent_t e;
    e.op = o; e.md = m; e.b = b;
    tab.push_back(e);
  endtask

  // ALU group rows in datasheet column order: (zp,x) zp # abs (zp),y zp,x abs,y abs,x
  task automatic alu(input opc_t o, input logic [63:0] row);
    put(o, M_IXID, row[63:56]); put(o, M_ZP, row[55:48]);
    if (o != OP_STA) put(o, M_IMM, row[47:40]);
    put(o, M_ABS, row[39:32]); put(o, M_IDIX, row[31:24]);
    put(o, M_ZPX, row[23:16]); put(o, M_ABSY, row[15:8]); put(o, M_ABSX, row[7:0]);
  endtask

  task automatic build_table();
    alu(OP_ORA, 64'h01_05_09_0D_11_15_19_1D); alu(OP_AND, 64'h21_25_29_2D_31_35_39_3D);
    alu(OP_EOR, 64'h41_45_49_4D_51_55_59_5D); alu(OP_ADC, 64'h61_65_69_6D_71_75_79_7D);
    alu(OP_STA, 64'h81_85_00_8D_91_95_99_9D); alu(OP_LDA, 64'hA1_A5_A9_AD_B1_B5_B9_BD);
    alu(OP_CMP, 64'hC1_C5_C9_CD_D1_D5_D9_DD); alu(OP_SBC, 64'hE1_E5_E9_ED_F1_F5_F9_FD);
    put(OP_ASL, M_ACC, 8'h0A); put(OP_ASL, M_ZP, 8'h06); put(OP_ASL, M_ABS, 8'h0E); put(OP_ASL, M_ZPX, 8'h16); put(OP_ASL, M_ABSX, 8'h1E);
    put(OP_ROL, M_ACC, 8'h2A); put(OP_ROL, M_ZP, 8'h26); put(OP_ROL, M_ABS, 8'h2E); put(OP_ROL, M_ZPX, 8'h36); put(OP_ROL, M_ABSX, 8'h3E);
    put(OP_LSR, M_ACC, 8'h4A); put(OP_LSR, M_ZP, 8'h46); put(OP_LSR, M_ABS, 8'h4E); put(OP_LSR, M_ZPX, 8'h56); put(OP_LSR, M_ABSX, 8'h5E);
    put(OP_ROR, M_ACC, 8'h6A); put(OP_ROR, M_ZP, 8'h66); put(OP_ROR, M_ABS, 8'h6E); put(OP_ROR, M_ZPX, 8'h76); put(OP_ROR, M_ABSX, 8'h7E);
    put(OP_STX, M_ZP, 8'h86); put(OP_STX, M_ABS, 8'h8E); put(OP_STX, M_ZPY, 8'h96);
    put(OP_LDX, M_IMM, 8'hA2); put(OP_LDX, M_ZP, 8'hA6); put(OP_LDX, M_ABS, 8'hAE); put(OP_LDX, M_ZPY, 8'hB6); put(OP_LDX, M_ABSY, 8'hBE);
    put(OP_DEC, M_ZP, 8'hC6); put(OP_DEC, M_ABS, 8'hCE); put(OP_DEC, M_ZPX, 8'hD6); put(OP_DEC, M_ABSX, 8'hDE);
    put(OP_INC, M_ZP, 8'hE6); put(OP_INC, M_ABS, 8'hEE); put(OP_INC, M_ZPX, 8'hF6); put(OP_INC, M_ABSX, 8'hFE);
    put(OP_BIT, M_ZP, 8'h24); put(OP_BIT, M_ABS, 8'h2C); put(OP_JMP, M_ABS, 8'h4C);
    put(OP_STY, M_ZP, 8'h84); put(OP_STY, M_ABS, 8'h8C); put(OP_STY, M_ZPX, 8'h94);
    put(OP_LDY, M_IMM, 8'hA0); put(OP_LDY, M_ZP, 8'hA4); put(OP_LDY, M_ABS, 8'hAC); put(OP_LDY, M_ZPX, 8'hB4); put(OP_LDY, M_ABSX, 8'hBC);
    put(OP_CPY, M_IMM, 8'hC0); put(OP_CPY, M_ZP, 8'hC4); put(OP_CPY, M_ABS, 8'hCC);
    put(OP_CPX, M_IMM, 8'hE0); put(OP_CPX, M_ZP, 8'hE4); put(OP_CPX, M_ABS, 8'hEC);
    put(OP_BRK, M_IMP, 8'h00); put(OP_RTI, M_IMP, 8'h40); put(OP_RTS, M_IMP, 8'h60); put(OP_PHP, M_IMP, 8'h08);
    put(OP_PLP, M_IMP, 8'h28); put(OP_PHA, M_IMP, 8'h48); put(OP_PLA, M_IMP, 8'h68); put(OP_CLC, M_IMP, 8'h18);
    put(OP_SEC, M_IMP, 8'h38); put(OP_CLI, M_IMP, 8'h58); put(OP_SEI, M_IMP, 8'h78); put(OP_CLV, M_IMP, 8'hB8);
    put(OP_CLD, M_IMP, 8'hD8); put(OP_SED, M_IMP, 8'hF8); put(OP_TYA, M_IMP, 8'h98); put(OP_DEY, M_IMP, 8'h88);
    put(OP_TAY, M_IMP, 8'hA8); put(OP_INY, M_IMP, 8'hC8); put(OP_INX, M_IMP, 8'hE8); put(OP_TXA, M_IMP, 8'h8A);
    put(OP_TXS, M_IMP, 8'h9A); put(OP_TAX, M_IMP, 8'hAA); put(OP_TSX, M_IMP, 8'hBA); put(OP_DEX, M_IMP, 8'hCA);
    put(OP_NOP, M_IMP, 8'hEA); put(OP_JSR, M_ABS, 8'h20);
    put(OP_BPL, M_REL, 8'h10); put(OP_BMI, M_REL, 8'h30); put(OP_BVC, M_REL, 8'h50); put(OP_BVS, M_REL, 8'h70);
    put(OP_BCC, M_REL, 8'h90); put(OP_BCS, M_REL, 8'hB0); put(OP_BNE, M_REL, 8'hD0); put(OP_BEQ, M_REL, 8'hF0);
  endtask

  task automatic ref_enc(input opc_t o, input addmod_t m, output bit legal, output logic [7:0] b);
    legal = 1'b0;
    b = 8'h00;
    foreach (tab[i]) begin
      if (tab[i].op == o && tab[i].md == m) begin
        legal = 1'b1;
        b = tab[i].b;
      end
    end
  endtask

  function automatic int ref_len(input addmod_t m);
    if (m == M_IMP || m == M_ACC) return 1;
    if (m == M_ABS || m == M_ABSX || m == M_ABSY) return 3;
    return 2;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run(input opc_t o, input addmod_t m, input logic [15:0] opr, input int st_lo, input int st_hi);
    bit         legal;
    logic [7:0] b0;
    logic [7:0] bytes [3];
    int         n, st;
    ref_enc(o, m, legal, b0);
    n = ref_len(m);
    bytes[0] = b0; bytes[1] = opr[7:0]; bytes[2] = opr[15:8];
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opcode = o; in_mode = m; in_operand = opr;
    @(negedge clk);
    in_valid = 1'b0; in_operand = 16'($urandom);
    if (!legal) begin
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_valid", 32'(out_valid), 32'd0);
      check("err_addr_hold", 32'(out_addr), 32'(model_addr));
      @(negedge clk);
      check("err_one_cycle", 32'(err), 32'd0);
      check("err_still_no_valid", 32'(out_valid), 32'd0);
      check("err_back_idle", 32'(in_ready), 32'd1);
    end else begin
      for (int k = 0; k < n; k++) begin
        st = $urandom_range(st_hi, st_lo);
        for (int s = 0; s < st; s++) begin
          out_ready = 1'b0;
          #1;
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(bytes[k]));
          check("stall_addr", 32'(out_addr), 32'(model_addr));
          check("stall_no_done", 32'(instr_done), 32'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("byte_valid", 32'(out_valid), 32'd1);
        check("byte_data", 32'(out_data), 32'(bytes[k]));
        check("byte_addr", 32'(out_addr), 32'(model_addr));
        check("instr_done", 32'(instr_done), (k == n - 1) ? 32'd1 : 32'd0);
        check("no_err", 32'(err), 32'd0);
        @(negedge clk);
        model_addr = model_addr + 16'd1;
      end
      out_ready = 1'b0;
      #1;
      check("end_valid_low", 32'(out_valid), 32'd0);
      check("end_in_ready", 32'(in_ready), 32'd1);
      check("end_addr", 32'(out_addr), 32'(model_addr));
    end
  endtask

  task automatic load(input logic [15:0] a, input bit with_valid);
    load_en = 1'b1; load_addr = a;
    in_valid = with_valid; in_opcode = OP_NOP; in_mode = M_IMP; in_operand = 16'h0000;
    #1;
    check("load_blocks_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    load_en = 1'b0; in_valid = 1'b0; load_addr = 16'($urandom);
    #1;
    check("load_addr", 32'(out_addr), 32'(a));
    check("load_no_accept", 32'(out_valid), 32'd0);
    check("load_no_err", 32'(err), 32'd0);
    model_addr = a;
  endtask

  initial begin
    build_table();
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = OP_NOP; in_mode = M_IMP; in_operand = 16'h0000;
    load_en = 1'b0; load_addr = 16'h0000; out_ready = 1'b0;
    model_addr = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_addr", 32'(out_addr), 32'h0000);
    check("rst_instr_done", 32'(instr_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load(16'h0200, 1'b0);
    run(OP_LDA, M_IMM, 16'h0042, 0, 0);
    check("lda_next_addr", 32'(model_addr), 32'h0202);
    run(OP_STA, M_ABS, 16'h1234, 3, 3);
    run(OP_LDX, M_ABSY, 16'hC000, 0, 1);
    run(OP_STX, M_ZPY, 16'h0010, 0, 1);
    run(OP_ROL, M_ACC, 16'hFFFF, 0, 1);
    run(OP_STA, M_IMM, 16'h0055, 0, 0);
    run(OP_JMP, M_ZPX, 16'h0055, 0, 0);
    run(OP_LDA, M_ZP, 16'h0077, 0, 0);

    load(16'hFFFF, 1'b1);
    run(OP_JMP, M_ABS, 16'h8000, 0, 0);
    check("wrap_addr", 32'(out_addr), 32'h0002);

    for (int o = 0; o <= int'(OP_BEQ); o++)
      for (int m = 0; m <= int'(M_REL); m++)
        run(opc_t'(o), addmod_t'(m), 16'($urandom), 0, 2);

    // reset while the high operand byte is being presented
    load(16'h3000, 1'b0);
    in_valid = 1'b1; in_opcode = OP_LDA; in_mode = M_ABS; in_operand = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("hib_valid", 32'(out_valid), 32'd1);
    check("hib_data", 32'(out_data), 32'hBE);
    check("hib_addr", 32'(out_addr), 32'h3002);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_addr", 32'(out_addr), 32'h0000);
    check("midrst_data", 32'(out_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_addr = 16'h0000;
    @(negedge clk);
    run(OP_NOP, M_IMP, 16'h0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
